// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: periodic serial-ADC conversion sequencer that streams
// each sample to a UART byte interface as a {0xA,hi-nibble},{low byte} frame.
module adc_frame_scheduler #(
    parameter int SAMPLE_DIV = 10000,
    parameter int SCLK_DIV   = 4,
    parameter int SHIFT_BITS = 16,
    parameter int ADC_BITS   = 12
) (
    input  logic        CLK_i,
    input  logic        RSTn_i,
    input  logic        EN_i,
    output logic        CS_o,
    output logic        SCLK_o,
    input  logic        SDO_i,
    output logic [7:0]  TX_DATA_o,
    output logic        TX_VALID_o,
    input  logic        TX_READY_i,
    output logic [11:0] SAMPLE_o,
    output logic        SAMPLE_VALID_o,
    output logic        OVERRUN_o
);
    localparam int TW   = $clog2(SAMPLE_DIV);
    localparam int DW   = $clog2(SCLK_DIV + 1);
    localparam int SEGS = 2 * SHIFT_BITS + 1;
    localparam int SW   = $clog2(SEGS + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONV    = 3'd1;
    localparam logic [2:0] DONE    = 3'd2;
    localparam logic [2:0] SEND_HI = 3'd3;
    localparam logic [2:0] SEND_LO = 3'd4;

    logic [TW-1:0]       timer_q, timer_d;
    logic [2:0]          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [SW-1:0]       seg_q, seg_d;
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic [11:0]         sample_q, sample_d;
    logic                ovr_q, ovr_d;
    logic                trig, div_end, conv_end, xfer;

    // A conversion is a chain of SCLK_DIV-long segments: even segments hold
    // SCLK high (segment 0 is setup), odd segments hold it low.  Only the
    // last ADC_BITS shifted bits survive in the shift register.
    always_comb begin
        trig     = EN_i && (timer_q == TW'(SAMPLE_DIV - 1));
        timer_d  = (!EN_i || trig) ? '0 : timer_q + 1'b1;
        ovr_d    = !EN_i ? 1'b0 : (trig && state_q != IDLE) ? 1'b1 : ovr_q;
        div_end  = div_q == DW'(SCLK_DIV - 1);
        conv_end = state_q == CONV && div_end && seg_q == SW'(SEGS - 1);
        xfer     = TX_VALID_o && TX_READY_i;
        div_d    = state_q != CONV ? '0 : div_end ? '0 : div_q + 1'b1;
        seg_d    = state_q != CONV ? '0 : div_end ? seg_q + 1'b1 : seg_q;
        shift_d  = (state_q == CONV && div_end && seg_q[0]) ? {shift_q[ADC_BITS-2:0], SDO_i} : shift_q;
        sample_d = conv_end ? 12'(shift_q) : sample_q;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = trig ? CONV : IDLE;
            CONV:    state_d = conv_end ? DONE : CONV;
            DONE:    state_d = SEND_HI;
            SEND_HI: state_d = xfer ? SEND_LO : SEND_HI;
            SEND_LO: state_d = xfer ? IDLE : SEND_LO;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            timer_q  <= '0;
            state_q  <= IDLE;
            div_q    <= '0;
            seg_q    <= '0;
            shift_q  <= '0;
            sample_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            state_q  <= state_d;
            div_q    <= div_d;
            seg_q    <= seg_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            ovr_q    <= ovr_d;
        end
    end

    assign CS_o           = state_q != CONV;
    assign SCLK_o         = state_q != CONV || !seg_q[0];
    assign SAMPLE_VALID_o = state_q == DONE;
    assign TX_VALID_o     = state_q == SEND_HI || state_q == SEND_LO;
    assign TX_DATA_o      = state_q == SEND_HI ? {4'hA, sample_q[11:8]} :
                            state_q == SEND_LO ? sample_q[7:0] : 8'h00;
    assign SAMPLE_o       = sample_q;
    assign OVERRUN_o      = ovr_q;
endmodule
